// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared definitions for the MM:SS countdown timer: state encoding and BCD limits.
package countdown_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  // True when all four BCD digits read zero (time is 00:00).
  function automatic logic bcd_time_is_zero(input logic [15:0] digits);
    return (digits == 16'h0000);
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_bcd_pair.sv
// Two-digit BCD register (tens/ones) that can decrement with borrow or increment with wrap.
module bcd_pair_down_inc
  import countdown_timer_ctrl_pkg::*;
#(
  parameter logic [3:0] TENS_MAX = SEC_TENS_MAX
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clr,
  input  logic       dec_en,
  input  logic       inc_en,
  input  logic       borrow_in,
  output logic [3:0] dec10,
  output logic [3:0] dec1,
  output logic       borrow_out
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       dec_go;

  // A decrement needs both the local enable and the request from the lower stage.
  assign dec_go     = dec_en & borrow_in;
  assign borrow_out = dec_go & (tens_q == 4'd0) & (ones_q == 4'd0);
  assign dec10      = tens_q;
  assign dec1       = ones_q;

  // Next digit values: clear beats decrement beats increment; wraps stay inside 00..TENS_MAX9.
  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clr) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (dec_go) begin
      if (ones_q == 4'd0) begin
        ones_d = DIGIT_MAX;
        tens_d = (tens_q == 4'd0) ? TENS_MAX : tens_q - 4'd1;
      end else begin
        ones_d = ones_q - 4'd1;
      end
    end else if (inc_en) begin
      if (ones_q >= DIGIT_MAX) begin
        ones_d = 4'd0;
        tens_d = (tens_q >= TENS_MAX) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  // Digit registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// MM:SS countdown timer: set in IDLE, count down in RUN, freeze in PAUSE, signal in ALARM.
module countdown_timer_ctrl #(
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       running,
  output logic       alarm,
  output logic [1:0] state
);
  import countdown_timer_ctrl_pkg::*;

  state_e     state_q, state_d;
  logic [5:0] acnt_q, acnt_d;
  logic [6:0] acnt_inc;

  logic       digit_clr;
  logic       sec_dec_en;
  logic       inc_min_en;
  logic       inc_sec_en;
  logic       sec_borrow;
  logic       min_borrow;
  logic       time_zero;
  logic       time_one;

  assign time_zero = bcd_time_is_zero({min10, min1, sec10, sec1});
  assign time_one  = ({min10, min1, sec10, sec1} == 16'h0001);
  assign acnt_inc  = {1'b0, acnt_q} + 7'd1;

  bcd_pair_down_inc #(.TENS_MAX(SEC_TENS_MAX)) u_sec (
    .clk       (clk),
    .reset_p   (reset_p),
    .clr       (digit_clr),
    .dec_en    (sec_dec_en),
    .inc_en    (inc_sec_en),
    .borrow_in (1'b1),
    .dec10     (sec10),
    .dec1      (sec1),
    .borrow_out(sec_borrow)
  );

  // Minutes decrement only when the seconds pair borrows on a live tick.
  bcd_pair_down_inc #(.TENS_MAX(SEC_TENS_MAX)) u_min (
    .clk       (clk),
    .reset_p   (reset_p),
    .clr       (digit_clr),
    .dec_en    (sec_borrow),
    .inc_en    (inc_min_en),
    .borrow_in (sec_dec_en),
    .dec10     (min10),
    .dec1      (min1),
    .borrow_out(min_borrow)
  );

  // State register and alarm tick counter.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= ST_IDLE;
      acnt_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      acnt_q  <= acnt_d;
    end
  end

  // Next state and alarm counter, honouring clear > start > tick priority.
  always_comb begin
    state_d = state_q;
    acnt_d  = 6'd0;
    unique case (state_q)
      ST_IDLE: begin
        if (!btn_clear && btn_start && !time_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (btn_clear)                                    state_d = ST_IDLE;
        else if (btn_start)                               state_d = ST_PAUSE;
        // An underflow borrow cannot normally occur; treat it as expiry too.
        else if ((clk_sec && time_one) || min_borrow)     state_d = ST_ALARM;
      end
      ST_PAUSE: begin
        if (btn_clear)      state_d = ST_IDLE;
        else if (btn_start) state_d = ST_RUN;
      end
      ST_ALARM: begin
        acnt_d = acnt_q;
        if (btn_clear || btn_start) begin
          state_d = ST_IDLE;
          acnt_d  = 6'd0;
        end else if (clk_sec) begin
          if (acnt_inc >= 7'(ALARM_SEC)) begin
            state_d = ST_IDLE;
            acnt_d  = 6'd0;
          end else begin
            acnt_d = acnt_inc[5:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath strobes and status decoded from the registered state.
  always_comb begin
    digit_clr  = btn_clear;
    sec_dec_en = 1'b0;
    inc_min_en = 1'b0;
    inc_sec_en = 1'b0;
    running    = (state_q == ST_RUN);
    alarm      = (state_q == ST_ALARM);
    unique case (state_q)
      ST_IDLE: begin
        // An effective start takes the cycle; an ignored start at 00:00 does not.
        if (!btn_clear && !(btn_start && !time_zero)) begin
          inc_min_en = btn_inc_min;
          inc_sec_en = btn_inc_sec;
        end
      end
      ST_RUN:  sec_dec_en = clk_sec & ~btn_clear & ~btn_start;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
